// File: rtl/uart_bus_master.sv
// UART command frames ('W' addr data / 'R' addr) become single-cycle bus writes/reads with a serial reply.
// Strobe one cycle after the last frame byte; reply bytes paced by uart_tx_busy; rx bytes dropped while replying.
module uart_tool_rx #(
   parameter int CLOCK_FREQ = 25000000,
   parameter int BIT_RATE   = 9600
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_rxd,
   output logic       uart_rx_valid,
   output logic       uart_rx_break,
   output logic [7:0] uart_rx_data
);
   localparam int CPB = CLOCK_FREQ / BIT_RATE;
   localparam int CW  = $clog2(CPB + 1);

   logic [1:0]    sync;
   logic          active;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync          <= 2'b11;
         active        <= 1'b0;
         cnt           <= '0;
         bit_idx       <= '0;
         uart_rx_valid <= 1'b0;
         uart_rx_break <= 1'b0;
         uart_rx_data  <= '0;
      end else begin
         sync          <= {sync[0], uart_rxd};
         uart_rx_valid <= 1'b0;
         uart_rx_break <= 1'b0;
         if (!active) begin
            if (!sync[1]) begin
               active  <= 1'b1;
               cnt     <= CW'(CPB / 2 - 1);
               bit_idx <= '0;
            end
         end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end else begin
            cnt     <= CW'(CPB - 1);
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd0) begin
               // a start bit that is high again at mid-bit was a glitch
               if (sync[1]) active <= 1'b0;
            end else if (bit_idx <= 4'd8) begin
               uart_rx_data <= {sync[1], uart_rx_data[7:1]};
            end else begin
               active <= 1'b0;
               if (sync[1])
                  uart_rx_valid <= 1'b1;
               else if (uart_rx_data == 8'h00)
                  uart_rx_break <= 1'b1;
            end
         end
      end
   end
endmodule

// 8N1 serialiser; busy from the cycle after uart_tx_en until the stop bit completes.
module uart_tool_tx #(
   parameter int CLOCK_FREQ = 25000000,
   parameter int BIT_RATE   = 9600
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_tx_en,
   input  logic [7:0] uart_tx_data,
   output logic       uart_txd,
   output logic       uart_tx_busy
);
   localparam int CPB = CLOCK_FREQ / BIT_RATE;
   localparam int CW  = $clog2(CPB + 1);

   logic [9:0]    sh;
   logic [3:0]    bits_left;
   logic [CW-1:0] cnt;

   assign uart_txd     = sh[0];
   assign uart_tx_busy = (bits_left != 4'd0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sh        <= '1;
         bits_left <= '0;
         cnt       <= '0;
      end else if (bits_left == 4'd0) begin
         if (uart_tx_en) begin
            sh        <= {1'b1, uart_tx_data, 1'b0};
            bits_left <= 4'd10;
            cnt       <= CW'(CPB - 1);
         end
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end else begin
         sh        <= {1'b1, sh[9:1]};
         bits_left <= bits_left - 4'd1;
         cnt       <= CW'(CPB - 1);
      end
   end
endmodule

module uart_bus_master #(
   parameter int CLOCK_FREQ     = 25000000,
   parameter int BIT_RATE       = 9600,
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic        tx,
   output logic        read,
   output logic        write,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   output logic        busy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WRITE, BUS_READ, RESP, RESP_WAIT} state_t;

   state_t        state, state_nxt;
   logic          rx_valid, rx_break;
   logic [7:0]    rx_data;
   logic          tx_busy, tx_en;
   logic          is_write;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] timeout_cnt;
   logic          timed_out;
   logic [31:0]   resp_sr;
   logic [2:0]    resp_cnt;

   uart_tool_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BIT_RATE(BIT_RATE)) u_rx (
      .clk(clk), .resetn(~reset), .uart_rxd(rx),
      .uart_rx_valid(rx_valid), .uart_rx_break(rx_break), .uart_rx_data(rx_data)
   );

   uart_tool_tx #(.CLOCK_FREQ(CLOCK_FREQ), .BIT_RATE(BIT_RATE)) u_tx (
      .clk(clk), .resetn(~reset), .uart_tx_en(tx_en), .uart_tx_data(resp_sr[31:24]),
      .uart_txd(tx), .uart_tx_busy(tx_busy)
   );

   assign timed_out = (timeout_cnt == TW'(TIMEOUT_CYCLES));
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      read      = 1'b0;
      write     = 1'b0;
      tx_en     = 1'b0;
      case (state)
         IDLE:
            if (rx_valid)
               state_nxt = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : RESP;
         ADDR:
            if (rx_break || timed_out)
               state_nxt = IDLE;
            else if (rx_valid && byte_cnt == 2'd3)
               state_nxt = is_write ? DATA : BUS_READ;
         DATA:
            if (rx_break || timed_out)
               state_nxt = IDLE;
            else if (rx_valid && byte_cnt == 2'd3)
               state_nxt = BUS_WRITE;
         BUS_WRITE: begin
            write     = 1'b1;
            state_nxt = RESP;
         end
         BUS_READ: begin
            read      = 1'b1;
            state_nxt = RESP;
         end
         RESP:
            if (!tx_busy) begin
               tx_en     = 1'b1;
               state_nxt = RESP_WAIT;
            end
         RESP_WAIT:
            if (byte_cnt == 2'd1)
               state_nxt = (resp_cnt == 3'd1) ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         is_write    <= 1'b0;
         byte_cnt    <= '0;
         timeout_cnt <= '0;
         address     <= '0;
         write_data  <= '0;
         resp_sr     <= '0;
         resp_cnt    <= '0;
      end else begin
         state <= state_nxt;

         // byte_cnt doubles as the two-cycle hold counter in RESP_WAIT
         if (state_nxt != state)
            byte_cnt <= '0;
         else if (((state == ADDR || state == DATA) && rx_valid) || state == RESP_WAIT)
            byte_cnt <= byte_cnt + 2'd1;

         if (state_nxt != state || rx_valid || !(state == ADDR || state == DATA))
            timeout_cnt <= '0;
         else if (!timed_out)
            timeout_cnt <= timeout_cnt + TW'(1);

         case (state)
            IDLE:
               if (rx_valid) begin
                  is_write <= (rx_data == 8'h57);
                  resp_sr  <= {8'h3F, 24'h0};
                  resp_cnt <= 3'd1;
               end
            ADDR:
               if (rx_valid && state_nxt != IDLE)
                  address <= {address[23:0], rx_data};
            DATA:
               if (rx_valid && state_nxt != IDLE)
                  write_data <= {write_data[23:0], rx_data};
            BUS_WRITE: begin
               resp_sr  <= {8'h4B, 24'h0};
               resp_cnt <= 3'd1;
            end
            BUS_READ: begin
               resp_sr  <= read_data;
               resp_cnt <= 3'd4;
            end
            RESP_WAIT:
               if (byte_cnt == 2'd1) begin
                  resp_sr  <= {resp_sr[23:0], 8'h00};
                  resp_cnt <= resp_cnt - 3'd1;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_bus_master.sv
// Drives serial frames into uart_bus_master, acts as the bus slave and decodes the serial reply.
module tb_uart_bus_master;
   localparam int CF  = 1000000;
   localparam int BR  = 100000;
   localparam int TO  = 400;
   localparam int CPB = CF / BR;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        tx, read, write, busy;
   logic [31:0] address, write_data;
   logic [31:0] read_data = '0;

   always #5 clk = ~clk;

   uart_bus_master #(.CLOCK_FREQ(CF), .BIT_RATE(BR), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rx(rx), .tx(tx), .read(read), .write(write),
      .address(address), .write_data(write_data), .read_data(read_data), .busy(busy)
   );

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_op_t;

   bus_op_t     exp_bus[$];
   logic [7:0]  exp_reply[$];
   logic [7:0]  rx_log[$];
   logic [31:0] model_mem[logic [31:0]];
   logic [31:0] slave_mem[logic [31:0]];
   logic [31:0] model_wd = '0;
   int          checks = 0, errors = 0;
   int          cyc = 0, stop_cyc = 0;
   int          wr_count = 0, rd_count = 0;
   logic [31:0] last_addr = '0, last_wd = '0;
   bit          mon_abort = 1'b0;
   bit          prev_strobe = 1'b0;

   function automatic logic [31:0] mem_default(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Frame-level reference: what a complete frame must do on the bus and on the reply line
   task automatic model_frame(input logic [7:0] fr[9], input int len);
      bus_op_t     op;
      logic [31:0] a, d, r;
      a = {fr[1], fr[2], fr[3], fr[4]};
      d = {fr[5], fr[6], fr[7], fr[8]};
      if (fr[0] == 8'h57 && len == 9) begin
         op = '{is_wr: 1'b1, addr: a, wdata: d};
         exp_bus.push_back(op);
         model_mem[a] = d;
         model_wd     = d;
         exp_reply.push_back(8'h4B);
      end else if (fr[0] == 8'h52 && len == 5) begin
         op = '{is_wr: 1'b0, addr: a, wdata: model_wd};
         exp_bus.push_back(op);
         r = model_mem.exists(a) ? model_mem[a] : mem_default(a);
         for (int i = 3; i >= 0; i--) exp_reply.push_back(r[i*8 +: 8]);
      end else begin
         exp_reply.push_back(8'h3F);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk) rx = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) rx = b[i];
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk) rx = 1'b1;
      stop_cyc = cyc;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic do_frame(input logic [7:0] fr[9], input int len);
      model_frame(fr, len);
      for (int i = 0; i < len; i++) send_byte(fr[i]);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((exp_reply.size() != 0 || exp_bus.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) fail("reply_timeout", 32'(exp_reply.size()), 32'd0);
      repeat (2 * CPB) @(negedge clk);
      chk_eq("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   always @(posedge clk) cyc++;

   // bus slave
   always @(negedge clk) begin
      if (write) slave_mem[address] = write_data;
      read_data = read ? (slave_mem.exists(address) ? slave_mem[address] : mem_default(address)) : 32'h0;
   end

   // bus compare
   always @(negedge clk) begin
      bus_op_t op;
      if (!reset) begin
         if (read || write) begin
            chk_eq("rd_wr_exclusive", {31'd0, read & write}, 32'd0);
            if (prev_strobe) fail("strobe_width", 32'd2, 32'd1);
            chk_eq("strobe_latency_ok", 32'((cyc - stop_cyc) >= 1 && (cyc - stop_cyc) <= 2 * CPB), 32'd1);
            if (exp_bus.size() == 0) begin
               fail("unexpected_strobe", address, 32'd0);
            end else begin
               op = exp_bus.pop_front();
               chk_eq("bus_kind_write", {31'd0, write}, {31'd0, op.is_wr});
               chk_eq("bus_address", address, op.addr);
               chk_eq("bus_write_data", write_data, op.wdata);
            end
            if (write) wr_count++;
            if (read) rd_count++;
            last_addr = address;
            last_wd   = write_data;
         end
         prev_strobe = read || write;
      end
   end

   // reply monitor
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (tx !== 1'b0) continue;
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         if (mon_abort) begin
            mon_abort = 1'b0;
            continue;
         end
         chk_eq("reply_stop_bit", {31'd0, tx}, 32'd1);
         if (exp_reply.size() == 0) fail("unexpected_reply_byte", {24'd0, b}, 32'd0);
         else chk_eq("reply_byte", {24'd0, b}, {24'd0, exp_reply.pop_front()});
         rx_log.push_back(b);
      end
   end

   initial begin
      logic [7:0]  fr[9];
      logic [31:0] a, d;
      int          n0, n, kind;

      repeat (3) @(negedge clk);
      chk_eq("reset_read", {31'd0, read}, 32'd0);
      chk_eq("reset_write", {31'd0, write}, 32'd0);
      chk_eq("reset_address", address, 32'd0);
      chk_eq("reset_write_data", write_data, 32'd0);
      chk_eq("reset_busy", {31'd0, busy}, 32'd0);
      chk_eq("reset_tx", {31'd0, tx}, 32'd1);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      fr = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'h41};
      do_frame(fr, 9);
      wait_done(1500);
      chk_eq("dir_wr_count", 32'(wr_count), 32'd1);
      chk_eq("dir_wr_addr", last_addr, 32'h0000_1003);
      chk_eq("dir_wr_data", last_wd, 32'h0000_0041);
      chk_eq("dir_wr_reply", {24'd0, rx_log[rx_log.size()-1]}, 32'h4B);
      chk_eq("dir_addr_held", address, 32'h0000_1003);

      slave_mem[32'h1003] = 32'hDEAD_BEEF;
      model_mem[32'h1003] = 32'hDEAD_BEEF;
      fr = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame(fr, 5);
      wait_done(1500);
      chk_eq("dir_rd_count", 32'(rd_count), 32'd1);
      chk_eq("dir_rd_addr", last_addr, 32'h0000_1003);
      n = rx_log.size();
      chk_eq("dir_rd_reply", {rx_log[n-4], rx_log[n-3], rx_log[n-2], rx_log[n-1]}, 32'hDEAD_BEEF);
      chk_eq("dir_rd_wdata_untouched", write_data, 32'h0000_0041);

      fr = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame(fr, 1);
      wait_done(1500);
      chk_eq("unk_reply", {24'd0, rx_log[rx_log.size()-1]}, 32'h3F);
      chk_eq("unk_no_strobe", 32'(wr_count + rd_count), 32'd2);
      fr = '{8'h52, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame(fr, 5);
      wait_done(1500);
      chk_eq("unk_then_read", 32'(rd_count), 32'd2);

      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (600) @(negedge clk);
      chk_eq("timeout_idle", {31'd0, busy}, 32'd0);
      fr = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame(fr, 5);
      wait_done(1500);
      chk_eq("timeout_no_write", 32'(wr_count), 32'd1);
      chk_eq("timeout_read_ok", 32'(rd_count), 32'd3);

      fr = '{8'h52, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame(fr, 5);
      send_byte(8'h57);
      wait_done(1500);
      chk_eq("inject_rd_count", 32'(rd_count), 32'd4);
      fr = '{8'h57, 8'h00, 8'h00, 8'h20, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78};
      do_frame(fr, 9);
      wait_done(1500);
      chk_eq("inject_then_write", 32'(wr_count), 32'd2);

      fr = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      n0 = rx_log.size();
      do_frame(fr, 5);
      n = 0;
      while (rx_log.size() < n0 + 1 && n < 1500) begin @(negedge clk); n++; end
      if (n >= 1500) fail("rst_first_byte_timeout", 32'(rx_log.size()), 32'(n0 + 1));
      n = 0;
      while (tx !== 1'b0 && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) fail("rst_second_start_timeout", {31'd0, tx}, 32'd0);
      repeat (30) @(negedge clk);
      mon_abort = 1'b1;
      exp_reply.delete();
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      model_wd = '0;
      chk_eq("rst_busy", {31'd0, busy}, 32'd0);
      chk_eq("rst_tx_idle", {31'd0, tx}, 32'd1);
      chk_eq("rst_address", address, 32'd0);
      repeat (500) @(negedge clk);
      chk_eq("rst_reply_truncated", 32'(rx_log.size() - n0), 32'd1);
      chk_eq("rst_first_byte", {24'd0, rx_log[rx_log.size()-1]}, 32'hDE);

      for (int k = 0; k < 25; k++) begin
         kind = $urandom_range(0, 9);
         a = ($urandom_range(0, 9) < 7) ? 32'h4000_0000 + 32'($urandom_range(0, 7)) * 32'd4 : $urandom;
         d = $urandom;
         if (kind < 4) begin
            fr = '{8'h57, a[31:24], a[23:16], a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
            do_frame(fr, 9);
         end else if (kind < 8) begin
            fr = '{8'h52, a[31:24], a[23:16], a[15:8], a[7:0], 8'h00, 8'h00, 8'h00, 8'h00};
            do_frame(fr, 5);
         end else begin
            fr[0] = 8'($urandom);
            while (fr[0] == 8'h57 || fr[0] == 8'h52) fr[0] = 8'($urandom);
            do_frame(fr, 1);
         end
         wait_done(1500);
      end
      chk_eq("end_bus_queue_empty", 32'(exp_bus.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
